// File: rtl/ustc_psum_accbuf.sv
// Ping-pong partial-sum accumulation buffer: beats scatter signed lane data into
// one column of the write bank; closed tiles drain column by column from the read bank.
module ustc_psum_accbuf #(
    parameter int M       = 16,
    parameter int N       = 16,
    parameter int NUM_IN  = 32,
    parameter int DW_DATA = 8,
    parameter int DW_ROW  = 4,
    parameter int DW_COL  = 4,
    parameter int DW_ACC  = 16,
    parameter int SAT     = 1
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [DW_COL-1:0]                      in_col,
    input  logic                                   in_last,
    input  logic [NUM_IN*(1+DW_ROW+DW_DATA)-1:0]   in,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [DW_COL-1:0]                      out_col,
    output logic [M*DW_ACC-1:0]                    out,
    output logic                                   err
);

    localparam int unsigned LW = 1 + DW_ROW + DW_DATA;
    localparam int unsigned SW = DW_ACC + $clog2(NUM_IN + 1);
    localparam logic signed [SW-1:0] MAXV = {{(SW-DW_ACC+1){1'b0}}, {(DW_ACC-1){1'b1}}};
    localparam logic signed [SW-1:0] MINV = {{(SW-DW_ACC+1){1'b1}}, {(DW_ACC-1){1'b0}}};

    logic signed [DW_ACC-1:0] bank_q [2][M][N];
    logic signed [DW_ACC-1:0] bank_d [2][M][N];
    logic [1:0]               full_q, full_d;
    logic                     wb_q, wb_d;
    logic                     rb_q, rb_d;
    logic [DW_COL-1:0]        out_col_q, out_col_d;
    logic                     err_q, err_d;

    logic                      lane_vld [NUM_IN];
    logic [DW_ROW-1:0]         lane_row [NUM_IN];
    logic signed [DW_DATA-1:0] lane_dat [NUM_IN];

    logic signed [SW-1:0]     row_sum [M];
    logic signed [DW_ACC-1:0] row_cur [M];
    logic signed [SW-1:0]     row_tot [M];
    logic signed [DW_ACC-1:0] row_red [M];

    logic accept, fire, col_ok, row_bad, last_col;

    // Lane unpack: {lane_vld, row, data}
    always_comb begin
        for (int i = 0; i < NUM_IN; i++) begin
            lane_vld[i] = in[i*LW + LW - 1];
            lane_row[i] = in[i*LW + DW_DATA +: DW_ROW];
            lane_dat[i] = in[i*LW +: DW_DATA];
        end
    end

    assign in_ready  = !full_q[wb_q];
    assign out_valid = full_q[rb_q];
    assign out_col   = out_col_q;
    assign err       = err_q;

    assign accept   = in_valid && in_ready;
    assign fire     = out_valid && out_ready;
    assign col_ok   = int'(in_col) < N;
    assign last_col = int'(out_col_q) == N - 1;

    // Per-row adder tree, add to stored value, then a single reduction to DW_ACC
    always_comb begin
        row_bad = 1'b0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (lane_vld[i] && int'(lane_row[i]) >= M) row_bad = 1'b1;
        end
        for (int r = 0; r < M; r++) begin
            row_sum[r] = '0;
            row_cur[r] = '0;
            for (int i = 0; i < NUM_IN; i++) begin
                if (lane_vld[i] && int'(lane_row[i]) == r)
                    row_sum[r] = row_sum[r] + SW'(lane_dat[i]);
            end
            for (int c = 0; c < N; c++) begin
                if (c == int'(in_col)) row_cur[r] = bank_q[wb_q][r][c];
            end
            row_tot[r] = SW'(row_cur[r]) + row_sum[r];
            row_red[r] = row_tot[r][DW_ACC-1:0];
            if (SAT != 0) begin
                if (row_tot[r] > MAXV)      row_red[r] = MAXV[DW_ACC-1:0];
                else if (row_tot[r] < MINV) row_red[r] = MINV[DW_ACC-1:0];
            end
        end
    end

    // Next state; a closing write and a final drain always target different banks
    always_comb begin
        bank_d    = bank_q;
        full_d    = full_q;
        wb_d      = wb_q;
        rb_d      = rb_q;
        out_col_d = out_col_q;
        err_d     = err_q;

        for (int b = 0; b < 2; b++) begin
            for (int r = 0; r < M; r++) begin
                for (int c = 0; c < N; c++) begin
                    if (accept && col_ok && b == int'(wb_q) && c == int'(in_col))
                        bank_d[b][r][c] = row_red[r];
                    if (fire && b == int'(rb_q) && c == int'(out_col_q))
                        bank_d[b][r][c] = '0;
                end
            end
        end

        if (accept && (!col_ok || row_bad)) err_d = 1'b1;

        if (accept && in_last) begin
            full_d[wb_q] = 1'b1;
            wb_d         = ~wb_q;
        end

        if (fire) begin
            if (last_col) begin
                full_d[rb_q] = 1'b0;
                rb_d         = ~rb_q;
                out_col_d    = '0;
            end else begin
                out_col_d = out_col_q + DW_COL'(1);
            end
        end
    end

    // Presented column of the read bank
    always_comb begin
        out = '0;
        if (full_q[rb_q]) begin
            for (int r = 0; r < M; r++) begin
                for (int c = 0; c < N; c++) begin
                    if (c == int'(out_col_q)) out[r*DW_ACC +: DW_ACC] = bank_q[rb_q][r][c];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++)
                for (int r = 0; r < M; r++)
                    for (int c = 0; c < N; c++)
                        bank_q[b][r][c] <= '0;
            full_q    <= '0;
            wb_q      <= 1'b0;
            rb_q      <= 1'b0;
            out_col_q <= '0;
            err_q     <= 1'b0;
        end else begin
            bank_q    <= bank_d;
            full_q    <= full_d;
            wb_q      <= wb_d;
            rb_q      <= rb_d;
            out_col_q <= out_col_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_ustc_psum_accbuf.sv
// Bench for ustc_psum_accbuf: a saturating and a wrapping instance share stimulus and
// are checked each cycle against a tile-queue reference model.
module tb_ustc_psum_accbuf;

    localparam int M  = 4;
    localparam int N  = 4;
    localparam int NI = 4;
    localparam int LW = 13;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n, in_valid, in_last, out_ready;
    logic [3:0]        in_col;
    logic [NI*LW-1:0]  in_bus;
    logic              rdy_s, rdy_w, vld_s, vld_w, err_s, err_w;
    logic [3:0]        col_s, col_w;
    logic [63:0]       out_s, out_w;

    ustc_psum_accbuf #(.M(M), .N(N), .NUM_IN(NI), .DW_DATA(8), .DW_ROW(4), .DW_COL(4),
                       .DW_ACC(16), .SAT(1)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_s), .in_col(in_col),
        .in_last(in_last), .in(in_bus), .out_valid(vld_s), .out_ready(out_ready),
        .out_col(col_s), .out(out_s), .err(err_s));

    ustc_psum_accbuf #(.M(M), .N(N), .NUM_IN(NI), .DW_DATA(8), .DW_ROW(4), .DW_COL(4),
                       .DW_ACC(16), .SAT(0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_w), .in_col(in_col),
        .in_last(in_last), .in(in_bus), .out_valid(vld_w), .out_ready(out_ready),
        .out_col(col_w), .out(out_w), .err(err_w));

    int nvec  = 0;
    int nfail = 0;

    int lv[NI], lr[NI], ld[NI];
    // reference model: current tile (row*4+col) plus FIFO of closed tiles, 16 entries each
    int acc_s[16], acc_w[16];
    int q_s[$], q_w[$];
    int ntiles, ocol;
    bit merr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    function automatic int sat16(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic int wrap16(input int v);
        int t;
        t = v & 32'hFFFF;
        if (t >= 32768) t -= 65536;
        return t;
    endfunction

    task automatic pack();
        for (int i = 0; i < NI; i++)
            in_bus[i*LW +: LW] = {1'(lv[i]), 4'(lr[i]), 8'(ld[i])};
    endtask

    task automatic clear_lanes();
        for (int i = 0; i < NI; i++) begin
            lv[i] = 0; lr[i] = 0; ld[i] = 0;
        end
        pack();
    endtask

    task automatic set_lane(input int i, input int v, input int r, input int d);
        lv[i] = v; lr[i] = r; ld[i] = d;
        pack();
    endtask

    task automatic rand_lanes();
        for (int i = 0; i < NI; i++) begin
            lv[i] = int'($urandom_range(0, 1));
            lr[i] = ($urandom_range(0, 15) == 0) ? int'($urandom_range(4, 15))
                                                 : int'($urandom_range(0, 3));
            ld[i] = int'($urandom_range(0, 255)) - 128;
        end
        pack();
    endtask

    task automatic model_reset();
        for (int k = 0; k < 16; k++) begin
            acc_s[k] = 0; acc_w[k] = 0;
        end
        q_s.delete(); q_w.delete();
        ntiles = 0; ocol = 0; merr = 1'b0;
    endtask

    task automatic model_beat();
        int sum[M];
        int c;
        c = int'(in_col);
        for (int r = 0; r < M; r++) sum[r] = 0;
        if (c >= N) merr = 1'b1;
        for (int i = 0; i < NI; i++) begin
            if (lv[i] != 0 && lr[i] >= M) merr = 1'b1;
            if (lv[i] != 0 && lr[i] < M && c < N) sum[lr[i]] += ld[i];
        end
        if (c < N) begin
            for (int r = 0; r < M; r++) begin
                acc_s[r*4+c] = sat16(acc_s[r*4+c] + sum[r]);
                acc_w[r*4+c] = wrap16(acc_w[r*4+c] + sum[r]);
            end
        end
        if (in_last) begin
            for (int k = 0; k < 16; k++) begin
                q_s.push_back(acc_s[k]); q_w.push_back(acc_w[k]);
                acc_s[k] = 0; acc_w[k] = 0;
            end
            ntiles++;
        end
    endtask

    task automatic model_drain();
        if (ocol == N - 1) begin
            for (int k = 0; k < 16; k++) begin
                void'(q_s.pop_front()); void'(q_w.pop_front());
            end
            ntiles--;
            ocol = 0;
        end else begin
            ocol++;
        end
    endtask

    task automatic check_all();
        logic [63:0] es, ew;
        chk("in_ready_sat",  64'(rdy_s), 64'(ntiles < 2));
        chk("in_ready_wrap", 64'(rdy_w), 64'(ntiles < 2));
        chk("out_valid_sat", 64'(vld_s), 64'(ntiles > 0));
        chk("out_valid_wrap",64'(vld_w), 64'(ntiles > 0));
        chk("err_sat",       64'(err_s), 64'(merr));
        chk("err_wrap",      64'(err_w), 64'(merr));
        if (ntiles > 0) begin
            for (int r = 0; r < M; r++) begin
                es[r*16 +: 16] = 16'(q_s[r*4+ocol]);
                ew[r*16 +: 16] = 16'(q_w[r*4+ocol]);
            end
            chk("out_col_sat",  64'(col_s), 64'(ocol));
            chk("out_col_wrap", 64'(col_w), 64'(ocol));
            chk("out_sat",  out_s, es);
            chk("out_wrap", out_w, ew);
        end
    endtask

    // One clock: check state, apply edge, advance model
    task automatic cycle();
        bit acc, fire;
        check_all();
        acc  = in_valid && (ntiles < 2);
        fire = out_ready && (ntiles > 0);
        @(posedge clk);
        if (fire) model_drain();
        if (acc)  model_beat();
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"},  64'({rdy_s, rdy_w}), 64'(2'b11));
        chk({tag, "_out_valid"}, 64'({vld_s, vld_w}), 64'(0));
        chk({tag, "_out_col"},   64'({col_s, col_w}), 64'(0));
        chk({tag, "_out_sat"},   out_s, 64'(0));
        chk({tag, "_out_wrap"},  out_w, 64'(0));
        chk({tag, "_err"},       64'({err_s, err_w}), 64'(0));
    endtask

    task automatic beat(input int col, input bit last);
        in_valid = 1'b1; in_col = 4'(col); in_last = last;
        cycle();
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic drain(input int n);
        out_ready = 1'b1;
        for (int k = 0; k < n; k++) cycle();
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0; in_col = '0;
        clear_lanes();
        model_reset();
        @(negedge clk); @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_all();

        // single-beat tile, duplicate rows summed, invalid lane ignored
        set_lane(0, 1, 0, 5); set_lane(1, 1, 0, 3); set_lane(2, 1, 2, -4); set_lane(3, 0, 3, 9);
        beat(1, 1'b1);
        chk("r032_valid", 64'(vld_s), 64'(1));
        out_ready = 1'b1;
        chk("r032_col0", out_s, 64'(0));
        cycle();
        chk("r032_col1", out_s, {16'd0, 16'hFFFC, 16'd0, 16'd8});
        drain(3);

        // long accumulation: saturate vs wrap
        clear_lanes();
        set_lane(0, 1, 1, 127);
        for (int k = 0; k < 300; k++) beat(0, k == 299);
        chk("r033_sat",  64'(out_s[31:16]), 64'(16'h7FFF));
        chk("r033_wrap", 64'(out_w[31:16]), 64'(16'h94D4));
        drain(4);

        // out-of-range row and column
        clear_lanes();
        set_lane(0, 1, 5, 7); set_lane(1, 1, 1, 10); set_lane(2, 1, 1, -3); set_lane(3, 0, 2, 99);
        beat(2, 1'b0);
        chk("r035_err", 64'(err_s), 64'(1));
        clear_lanes();
        set_lane(0, 1, 0, 50);
        beat(6, 1'b1);
        chk("r035_err_sticky", 64'(err_w), 64'(1));
        drain(2);
        chk("r035_row1", 64'(out_s[31:16]), 64'(16'd7));
        drain(2);

        // two full tiles with back-pressure
        for (int t = 0; t < 2; t++)
            for (int k = 0; k < 3; k++) begin
                rand_lanes();
                beat(int'($urandom_range(0, 3)), k == 2);
            end
        chk("r034_blocked", 64'(rdy_s), 64'(0));
        rand_lanes();
        in_valid = 1'b1; in_last = 1'b1;
        for (int k = 0; k < 3; k++) cycle();
        in_valid = 1'b0; in_last = 1'b0;
        drain(4);
        chk("r034_ready_after", 64'(rdy_s), 64'(1));
        drain(4);

        // async reset mid-drain
        for (int k = 0; k < 2; k++) begin
            rand_lanes();
            beat(k, k == 1);
        end
        drain(2);
        chk("r036_at_col2", 64'(col_s), 64'(2));
        rst_n = 1'b0;
        #2;
        model_reset();
        check_reset_outputs("r036");
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        clear_lanes();
        set_lane(0, 1, 3, -20); set_lane(1, 1, 3, 1);
        beat(2, 1'b1);
        drain(2);
        chk("r036_fresh", out_s, {16'hFFED, 48'd0});
        drain(2);

        // randomized traffic, including same-cycle close and final drain
        for (int k = 0; k < 600; k++) begin
            rand_lanes();
            in_valid  = ($urandom_range(0, 3) != 0);
            in_col    = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(4, 15))
                                                     : 4'($urandom_range(0, 3));
            in_last   = ($urandom_range(0, 4) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            cycle();
        end
        in_valid = 1'b0; out_ready = 1'b0;
        check_all();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
